// File: rtl/mpt_walker.sv
// Memory-protection table walker: checks one physical address per request by
// walking up to LEVELS levels of 9-bit-indexed tables and reports allow/fault.
module mpt_walker #(
  parameter int unsigned ADDR_LEN = 56,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned LEVELS   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_LEN-1:0]   req_paddr_i,
  input  logic [1:0]            req_access_i,
  input  logic [3:0]            mmpt_mode_i,
  input  logic [ADDR_LEN-13:0]  mmpt_ppn_i,
  output logic                  mem_req_o,
  output logic [ADDR_LEN-1:0]   mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_allow_o,
  output logic                  resp_access_fault_o,
  output logic [1:0]            resp_fmt_err_o,
  output logic [XLEN-1:0]       resp_entry_o,
  output logic                  busy_o
);

  localparam int unsigned CSPAN   = 12 + 9 * LEVELS;
  localparam int unsigned PPN_W   = ADDR_LEN - 12;
  localparam logic [1:0]  LVL_TOP = 2'(LEVELS - 1);

  typedef enum logic [2:0] {StIdle, StValidate, StReq, StWait, StResp, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] paddr_q, paddr_d;
  logic [1:0]          access_q, access_d;
  logic [3:0]          mode_q, mode_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic [1:0]          level_q, level_d;
  logic [ADDR_LEN-1:0] base_q, base_d;
  logic [XLEN-1:0]     entry_q, entry_d;
  logic                allow_q, allow_d;
  logic                fault_q, fault_d;
  logic [1:0]          fmt_q, fmt_d;

  logic [6:0]          shamt;
  logic [8:0]          idx;
  logic                range_bad;
  logic                e_v, e_leaf, e_r, e_w, e_x, e_rsvd, perm;
  logic [PPN_W-1:0]    e_ppn;

  assign req_ready_o = (state_q == StIdle) && !flush_i;
  assign busy_o      = (state_q != StIdle);
  assign mem_req_o   = (state_q == StReq);

  // Table index for the current level, scaled to an 8-byte entry offset.
  assign shamt      = 7'd12 + 7'd9 * {5'd0, level_q};
  assign idx        = 9'(paddr_q >> shamt);
  assign mem_addr_o = mem_req_o ? base_q + ADDR_LEN'({idx, 3'b000}) : '0;

  // A flush in the response cycle suppresses the response; all fields follow valid.
  assign resp_valid_o        = (state_q == StResp) && !flush_i;
  assign resp_allow_o        = resp_valid_o & allow_q;
  assign resp_access_fault_o = resp_valid_o & fault_q;
  assign resp_fmt_err_o      = resp_valid_o ? fmt_q : 2'd0;
  assign resp_entry_o        = resp_valid_o ? entry_q : '0;

  assign range_bad = (CSPAN < ADDR_LEN) && ((paddr_q >> CSPAN) != '0);

  // Entry field decode.
  assign e_v    = mem_rdata_i[0];
  assign e_leaf = mem_rdata_i[1];
  assign e_r    = mem_rdata_i[2];
  assign e_w    = mem_rdata_i[3];
  assign e_x    = mem_rdata_i[4];
  assign e_ppn  = mem_rdata_i[10 +: PPN_W];
  assign e_rsvd = (mem_rdata_i[XLEN-1:ADDR_LEN-2] != '0);

  // Permission bit selected by the latched access type.
  always_comb begin
    perm = 1'b0;
    unique case (access_q)
      2'd0:    perm = e_r;
      2'd1:    perm = e_w;
      2'd2:    perm = e_x;
      default: perm = 1'b0;
    endcase
  end

  // Next-state and result computation for the walk FSM.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    access_d = access_q;
    mode_d   = mode_q;
    ppn_d    = ppn_q;
    level_d  = level_q;
    base_d   = base_q;
    entry_d  = entry_q;
    allow_d  = allow_q;
    fault_d  = fault_q;
    fmt_d    = fmt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_o) begin
          paddr_d  = req_paddr_i;
          access_d = req_access_i;
          mode_d   = mmpt_mode_i;
          ppn_d    = mmpt_ppn_i;
          entry_d  = '0;
          allow_d  = 1'b0;
          fault_d  = 1'b0;
          fmt_d    = 2'd0;
          state_d  = StValidate;
        end
      end
      StValidate: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (mode_q == 4'd0) begin
          allow_d = 1'b1;
          state_d = StResp;
        end else if (mode_q != 4'd1 || access_q == 2'd3) begin
          fmt_d   = 2'd3;
          state_d = StResp;
        end else if (range_bad) begin
          fmt_d   = 2'd1;
          state_d = StResp;
        end else begin
          level_d = LVL_TOP;
          base_d  = {ppn_q, 12'h000};
          state_d = StReq;
        end
      end
      StReq: begin
        // A granted read must still be absorbed, so a concurrent flush drains.
        if (mem_gnt_i) begin
          state_d = flush_i ? StDrain : StWait;
        end else if (flush_i) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            entry_d = mem_rdata_i;
            state_d = StResp;
            if (!e_v) begin
              fault_d = 1'b1;
            end else if (e_rsvd) begin
              fmt_d = 2'd2;
            end else if (e_w && !e_r) begin
              fmt_d = 2'd3;
            end else if (e_leaf) begin
              allow_d = perm;
              fault_d = !perm;
            end else if (level_q == 2'd0) begin
              fmt_d = 2'd3;
            end else begin
              base_d  = {e_ppn, 12'h000};
              level_d = level_q - 2'd1;
              state_d = StReq;
            end
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        entry_d = '0;
        allow_d = 1'b0;
        fault_d = 1'b0;
        fmt_d   = 2'd0;
        state_d = StIdle;
      end
      StDrain: begin
        if (mem_rvalid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      access_q <= 2'd0;
      mode_q   <= 4'd0;
      ppn_q    <= '0;
      level_q  <= 2'd0;
      base_q   <= '0;
      entry_q  <= '0;
      allow_q  <= 1'b0;
      fault_q  <= 1'b0;
      fmt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      access_q <= access_d;
      mode_q   <= mode_d;
      ppn_q    <= ppn_d;
      level_q  <= level_d;
      base_q   <= base_d;
      entry_q  <= entry_d;
      allow_q  <= allow_d;
      fault_q  <= fault_d;
      fmt_q    <= fmt_d;
    end
  end

endmodule

// File: tb/tb_mpt_walker.sv
// Bench for mpt_walker: table of lookups with a memory model and a response scoreboard.
module tb_mpt_walker;
  localparam int unsigned AL = 56;
  localparam int unsigned XL = 64;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AL-1:0] req_paddr_i = '0;
  logic [1:0]    req_access_i = 2'd0;
  logic [3:0]    mmpt_mode_i = 4'd0;
  logic [AL-13:0] mmpt_ppn_i = '0;
  logic          mem_req_o;
  logic [AL-1:0] mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [XL-1:0] mem_rdata_i = '0;
  logic          resp_valid_o, resp_allow_o, resp_access_fault_o, busy_o;
  logic [1:0]    resp_fmt_err_o;
  logic [XL-1:0] resp_entry_o;

  mpt_walker #(.ADDR_LEN(AL), .XLEN(XL), .LEVELS(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_paddr_i(req_paddr_i), .req_access_i(req_access_i),
    .mmpt_mode_i(mmpt_mode_i), .mmpt_ppn_i(mmpt_ppn_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_allow_o(resp_allow_o),
    .resp_access_fault_o(resp_access_fault_o), .resp_fmt_err_o(resp_fmt_err_o),
    .resp_entry_o(resp_entry_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  typedef struct {
    logic        allow;
    logic        fault;
    logic [1:0]  fmt;
    logic [63:0] entry;
    int          due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [55:0] paddr;
    logic [1:0]  acc;
    logic [63:0] e2, e1, e0;
    logic        allow, fault;
    logic [1:0]  fmt;
    logic [63:0] entry;
    int          reads;
  } vec_t;

  // Memory model: grant in the request cycle, data rv_delay+1 cycles later.
  logic [63:0] ents[3];
  logic [55:0] exp_addr[3];
  int          reads_seen = 0;
  bit          pend = 0;
  int          cnt = 0;
  int          rv_delay = 0;
  logic [63:0] pend_data = '0;

  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data;
        pend = 0;
      end else begin
        cnt--;
      end
    end
    mem_gnt_i = mem_req_o;
    if (mem_req_o) begin
      chk("mem_read_index", 64'(reads_seen < 3), 64'd1);
      if (reads_seen < 3) begin
        chk("mem_addr", 64'(mem_addr_o), 64'(exp_addr[reads_seen]));
        pend_data = ents[reads_seen];
      end
      reads_seen++;
      pend = 1;
      cnt  = rv_delay;
    end
  end

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (resp_valid_o) begin
        chk("resp_expected", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("resp_allow", 64'(resp_allow_o), 64'(e.allow));
          chk("resp_fault", 64'(resp_access_fault_o), 64'(e.fault));
          chk("resp_fmt", 64'(resp_fmt_err_o), 64'(e.fmt));
          chk("resp_entry", resp_entry_o, e.entry);
          chk("resp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("resp_zero_idle", resp_entry_o | 64'({resp_allow_o, resp_access_fault_o,
            resp_fmt_err_o}), 64'd0);
      end
    end
  end

  task automatic send(input logic [3:0] mode, input logic [55:0] pa, input logic [1:0] acc,
                      input bit push, input exp_t e, input int lat);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid_i  = 1'b1;
    mmpt_mode_i  = mode;
    req_paddr_i  = pa;
    req_access_i = acc;
    mmpt_ppn_i   = 44'h80;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1;
        if (push) begin
          e.due = cyc + lat;
          sbq.push_back(e);
        end
        break;
      end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("req_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy_o && sbq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("walk_completes", 64'(ok), 64'd1);
    sbq.delete();
  endtask

  task automatic wait_grant();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (mem_gnt_i) begin
        ok = 1;
        break;
      end
    end
    chk("grant_seen", 64'(ok), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    ents[0] = v.e2;
    ents[1] = v.e1;
    ents[2] = v.e0;
    reads_seen = 0;
    e.allow = v.allow;
    e.fault = v.fault;
    e.fmt   = v.fmt;
    e.entry = v.entry;
    e.due   = 0;
    send(v.mode, v.paddr, v.acc, 1, e, 2 + 2 * v.reads);
    wait_idle();
    chk({"reads_", v.name}, 64'(reads_seen), 64'(v.reads));
  endtask

  localparam logic [55:0] PA   = 56'h0040201000;
  localparam logic [63:0] NL2  = 64'h20401;
  localparam logic [63:0] NL1  = 64'h20801;
  localparam logic [63:0] LR   = 64'h48C07;
  localparam logic [63:0] LX   = 64'h48C13;
  localparam logic [63:0] LRW  = 64'h48C0F;
  localparam logic [63:0] LWNR = 64'h48C0B;
  localparam logic [63:0] BIG  = 64'h8000000000020401;
  localparam logic [63:0] INV  = 64'h20400;
  localparam logic [63:0] SUP  = 64'h40007;

  vec_t vecs[14];

  initial begin
    exp_t none;
    bit   got;
    none = '{allow: 1'b0, fault: 1'b0, fmt: 2'd0, entry: 64'd0, due: 0};
    exp_addr[0] = 56'h80008;
    exp_addr[1] = 56'h81008;
    exp_addr[2] = 56'h82008;
    ents[0] = '0;
    ents[1] = '0;
    ents[2] = '0;
    //           name          mode  paddr               acc   e2   e1   e0    al fa fmt entry reads
    vecs[0]  = '{"bare_rd",    4'd0, 56'h1000,           2'd0, 0,   0,   0,    1, 0, 0, 0,    0};
    vecs[1]  = '{"walk_rd",    4'd1, PA,                 2'd0, NL2, NL1, LR,   1, 0, 0, LR,   3};
    vecs[2]  = '{"walk_wr",    4'd1, PA,                 2'd1, NL2, NL1, LR,   0, 1, 0, LR,   3};
    vecs[3]  = '{"walk_ex",    4'd1, PA,                 2'd2, NL2, NL1, LX,   1, 0, 0, LX,   3};
    vecs[4]  = '{"walk_rw",    4'd1, PA,                 2'd1, NL2, NL1, LRW,  1, 0, 0, LRW,  3};
    vecs[5]  = '{"range",      4'd1, PA | (56'd1 << 39), 2'd0, NL2, NL1, LR,   0, 0, 1, 0,    0};
    vecs[6]  = '{"w_no_r",     4'd1, PA,                 2'd0, NL2, NL1, LWNR, 0, 0, 3, LWNR, 3};
    vecs[7]  = '{"rsvd_bit",   4'd1, PA,                 2'd0, BIG, NL1, LR,   0, 0, 2, BIG,  1};
    vecs[8]  = '{"invalid",    4'd1, PA,                 2'd0, INV, NL1, LR,   0, 1, 0, INV,  1};
    vecs[9]  = '{"rsvd_mode",  4'd2, PA,                 2'd0, NL2, NL1, LR,   0, 0, 3, 0,    0};
    vecs[10] = '{"rsvd_acc",   4'd1, PA,                 2'd3, NL2, NL1, LR,   0, 0, 3, 0,    0};
    vecs[11] = '{"superpage",  4'd1, PA,                 2'd0, SUP, NL1, LR,   1, 0, 0, SUP,  1};
    vecs[12] = '{"nonleaf_l0", 4'd1, PA,                 2'd0, NL2, NL1, NL2,  0, 0, 3, NL2,  3};
    vecs[13] = '{"bare_wr",    4'd0, 56'h1000,           2'd1, 0,   0,   0,    1, 0, 0, 0,    0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready_o), 64'd1);

    // Flush held in IDLE blocks acceptance.
    flush_i = 1'b1;
    @(negedge clk);
    chk("ready_during_flush", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Flush while waiting for read data: drain, no response.
    ents[0] = NL2; ents[1] = NL1; ents[2] = LR;
    reads_seen = 0;
    rv_delay = 2;
    send(4'd1, PA, 2'd0, 0, none, 0);
    wait_grant();
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("busy_in_drain", 64'(busy_o), 64'd1);
      if (mem_rvalid_i) begin
        got = 1;
        break;
      end
    end
    chk("drain_rvalid_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("ready_after_drain", 64'(req_ready_o), 64'd1);
    chk("idle_after_drain", 64'(busy_o), 64'd0);
    rv_delay = 0;
    run_vec(vecs[1]);

    // Flush in VALIDATE: straight back to IDLE with no memory traffic.
    reads_seen = 0;
    send(4'd1, PA, 2'd0, 0, none, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("ready_after_vflush", 64'(req_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("no_read_after_vflush", 64'(reads_seen), 64'd0);

    // Reset mid-walk: walk dropped, stale read data ignored.
    reads_seen = 0;
    send(4'd1, PA, 2'd0, 0, none, 0);
    wait_grant();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", 64'(req_ready_o), 64'd1);
    chk("busy_after_midrst", 64'(busy_o), 64'd0);
    chk("memreq_after_midrst", 64'(mem_req_o), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_after_stale_rvalid", 64'(busy_o), 64'd0);
    run_vec(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
